// File: rtl/snn_ctrl_pkg.sv
// Shared definitions for the spiking-network inference controller:
// command opcodes, status-word bit positions and the controller FSM states.
package snn_ctrl_pkg;

  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_WRITE = 3'd1;
  localparam logic [2:0] OP_CLEAR = 3'd2;
  localparam logic [2:0] OP_START = 3'd3;
  localparam logic [2:0] OP_READ  = 3'd4;

  localparam int ST_BUSY    = 31;
  localparam int ST_DONE    = 30;
  localparam int ST_SAT     = 29;
  localparam int ST_WR_ERR  = 28;
  localparam int ST_WIN_LSB = 16;
  localparam int ST_RD_LSB  = 0;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RUN    = 3'd1,
    S_DRAIN  = 3'd2,
    S_ARGMAX = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  // A pass count of zero still streams the buffer once.
  function automatic logic [7:0] norm_passes(input logic [7:0] p);
    return (p == 8'd0) ? 8'd1 : p;
  endfunction

endpackage

// File: rtl/frame_buffer.sv
// Simple dual-port frame store: one write port, one synchronous read port.
// The read register parks at zero whenever no read is issued, so it can
// drive the network input directly.
module frame_buffer #(
  parameter int W      = 19,
  parameter int DEPTH  = 128,
  parameter int ADDR_W = 7
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [W-1:0]      wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [W-1:0]      rdata
);

  logic [W-1:0] mem [DEPTH];

  // Write port; storage is not reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Registered read port, zero when idle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)   rdata <= '0;
    else if (re) rdata <= mem[raddr];
    else         rdata <= '0;
  end

endmodule

// File: rtl/snn_inference_ctrl.sv
// Inference controller: buffers host-written frames, streams them into the
// external spiking network for P passes, accumulates saturating per-class
// spike counts, picks the winning class and reports via a status word.
module snn_inference_ctrl
  import snn_ctrl_pkg::*;
#(
  parameter int IN_W    = 19,
  parameter int OUT_N   = 10,
  parameter int DEPTH   = 128,
  parameter int ADDR_W  = 7,
  parameter int CNT_W   = 12,
  parameter int NET_LAT = 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             cmd_valid,
  input  logic [31:0]      data_in,
  output logic [31:0]      data_out,
  output logic [IN_W-1:0]  net_i,
  input  logic [OUT_N-1:0] net_o
);

  localparam logic [ADDR_W:0] DEPTH_C   = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] PTR_ONE   = (ADDR_W+1)'(1);
  localparam logic [4:0]      OUT_N_C   = 5'(OUT_N);
  localparam logic [3:0]      LAST_IDX  = 4'(OUT_N - 1);
  localparam logic [15:0]     NET_LAT_C = 16'(NET_LAT);

  state_t            state;
  logic [ADDR_W:0]   wr_ptr;
  logic [ADDR_W:0]   rd_addr;
  logic [7:0]        passes;
  logic [7:0]        pass_cnt;
  logic [15:0]       drain_cnt;
  logic [NET_LAT:0]  vld_pipe;
  logic [CNT_W-1:0]  count [OUT_N];
  logic [CNT_W-1:0]  cnt_next [OUT_N];
  logic [OUT_N-1:0]  cnt_full;
  logic              sat;
  logic              wr_err;
  logic              done;
  logic [3:0]        winner;
  logic [3:0]        scan_idx;
  logic [3:0]        best_idx;
  logic [CNT_W-1:0]  best_val;
  logic [15:0]       rd_reg;
  logic [15:0]       rd_sel;

  logic [2:0] op;
  logic [3:0] rd_idx;
  logic       busy;
  logic       cmd_clear;
  logic       cmd_ok;
  logic       do_write;
  logic       do_start;
  logic       do_read;
  logic       cmd_err;
  logic       rd_en;
  logic       cnt_en;
  logic       sat_hit;
  logic       last_read;
  logic       unused_payload;

  // Saturating add of one spike bit to a class counter.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic s);
    if (s && (&c)) return c;
    return c + {{(CNT_W-1){1'b0}}, s};
  endfunction

  assign op             = data_in[31:29];
  assign rd_idx         = data_in[3:0];
  assign unused_payload = ^data_in;

  assign busy      = (state == S_RUN) || (state == S_DRAIN) || (state == S_ARGMAX);
  assign cmd_clear = cmd_valid && (op == OP_CLEAR);
  assign cmd_ok    = cmd_valid && !busy;
  assign do_write  = cmd_ok && (op == OP_WRITE) && (wr_ptr != DEPTH_C);
  assign do_start  = cmd_ok && (op == OP_START) && (wr_ptr != '0);
  assign do_read   = cmd_ok && (op == OP_READ);
  assign cmd_err   = cmd_ok && (((op == OP_WRITE) && (wr_ptr == DEPTH_C)) ||
                                ((op == OP_START) && (wr_ptr == '0)));
  assign rd_en     = (state == S_RUN) && !cmd_clear;
  assign cnt_en    = vld_pipe[NET_LAT] && !cmd_clear;
  assign sat_hit   = cnt_en && (|(net_o & cnt_full));
  assign last_read = (rd_addr == (wr_ptr - PTR_ONE));

  frame_buffer #(
    .W      (IN_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_frame_buffer (
    .clk   (clk),
    .rstn  (rstn),
    .we    (do_write),
    .waddr (wr_ptr[ADDR_W-1:0]),
    .wdata (data_in[IN_W-1:0]),
    .re    (rd_en),
    .raddr (rd_addr[ADDR_W-1:0]),
    .rdata (net_i)
  );

  // Next counter values and per-class saturation flags.
  always_comb begin
    cnt_full = '0;
    for (int c = 0; c < OUT_N; c++) begin
      cnt_next[c] = sat_inc(count[c], net_o[c]);
      cnt_full[c] = &count[c];
    end
  end

  // Zero-extended counter selected by a READ; out-of-range classes read 0.
  always_comb begin
    rd_sel = '0;
    if ({1'b0, rd_idx} < OUT_N_C) rd_sel = 16'(count[rd_idx]);
  end

  // Valid tags follow each buffer read to the cycle its response is sampled.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld_pipe <= '0;
    end else if (cmd_clear) begin
      vld_pipe <= '0;
    end else begin
      vld_pipe[0] <= rd_en;
      for (int k = 1; k <= NET_LAT; k++) vld_pipe[k] <= vld_pipe[k-1];
    end
  end

  // Per-class spike counters with sticky saturation flag.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int c = 0; c < OUT_N; c++) count[c] <= '0;
      sat <= 1'b0;
    end else if (cmd_clear || do_start) begin
      for (int c = 0; c < OUT_N; c++) count[c] <= '0;
      sat <= 1'b0;
    end else if (cnt_en) begin
      for (int c = 0; c < OUT_N; c++) count[c] <= cnt_next[c];
      if (sat_hit) sat <= 1'b1;
    end
  end

  // Command handling and run sequencing FSM.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= S_IDLE;
      wr_ptr    <= '0;
      rd_addr   <= '0;
      passes    <= 8'd1;
      pass_cnt  <= '0;
      drain_cnt <= '0;
      scan_idx  <= '0;
      best_idx  <= '0;
      best_val  <= '0;
      winner    <= '0;
      done      <= 1'b0;
      wr_err    <= 1'b0;
      rd_reg    <= '0;
    end else if (cmd_clear) begin
      state   <= S_IDLE;
      wr_ptr  <= '0;
      rd_addr <= '0;
      winner  <= '0;
      done    <= 1'b0;
      wr_err  <= 1'b0;
    end else begin
      if (do_write) wr_ptr <= wr_ptr + PTR_ONE;
      if (cmd_err)  wr_err <= 1'b1;
      if (do_read)  rd_reg <= rd_sel;
      if (do_start) begin
        if (state == S_DONE) winner <= best_idx;
        state    <= S_RUN;
        passes   <= norm_passes(data_in[7:0]);
        pass_cnt <= '0;
        rd_addr  <= '0;
        done     <= 1'b0;
      end else begin
        case (state)
          S_IDLE: state <= S_IDLE;
          S_RUN: begin
            if (last_read) begin
              rd_addr <= '0;
              if (pass_cnt == (passes - 8'd1)) begin
                state     <= S_DRAIN;
                drain_cnt <= '0;
              end else begin
                pass_cnt <= pass_cnt + 8'd1;
              end
            end else begin
              rd_addr <= rd_addr + PTR_ONE;
            end
          end
          S_DRAIN: begin
            if (drain_cnt == NET_LAT_C) begin
              state    <= S_ARGMAX;
              scan_idx <= '0;
              best_idx <= '0;
              best_val <= '0;
            end else begin
              drain_cnt <= drain_cnt + 16'd1;
            end
          end
          S_ARGMAX: begin
            if (count[scan_idx] > best_val) begin
              best_val <= count[scan_idx];
              best_idx <= scan_idx;
            end
            if (scan_idx == LAST_IDX) state <= S_DONE;
            else                      scan_idx <= scan_idx + 4'd1;
          end
          S_DONE: begin
            done   <= 1'b1;
            winner <= best_idx;
            state  <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  // Status word assembly from registered fields.
  always_comb begin
    data_out                      = '0;
    data_out[ST_BUSY]             = busy;
    data_out[ST_DONE]             = done;
    data_out[ST_SAT]              = sat;
    data_out[ST_WR_ERR]           = wr_err;
    data_out[ST_WIN_LSB +: 4]     = winner;
    data_out[ST_RD_LSB +: 16]     = rd_reg;
  end

endmodule

// File: tb/tb_snn_inference_ctrl.sv
// Directed bench for snn_inference_ctrl with a one-cycle network stub whose
// spikes are the low OUT_N bits of the frame (all ones when no frame).
module tb_snn_inference_ctrl;
  import snn_ctrl_pkg::*;

  localparam int IN_W    = 19;
  localparam int OUT_N   = 10;
  localparam int DEPTH   = 128;
  localparam int ADDR_W  = 7;
  localparam int CNT_W   = 4;
  localparam int NET_LAT = 1;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic             cmd_valid = 1'b0;
  logic [31:0]      data_in = '0;
  logic [31:0]      data_out;
  logic [IN_W-1:0]  net_i;
  logic [OUT_N-1:0] net_o = '0;

  int nvec = 0;
  int nerr = 0;
  int lat;

  always #5 clk = ~clk;

  snn_inference_ctrl #(
    .IN_W(IN_W), .OUT_N(OUT_N), .DEPTH(DEPTH), .ADDR_W(ADDR_W),
    .CNT_W(CNT_W), .NET_LAT(NET_LAT)
  ) dut (
    .clk(clk), .rstn(rstn), .cmd_valid(cmd_valid), .data_in(data_in),
    .data_out(data_out), .net_i(net_i), .net_o(net_o)
  );

  // Network stub: one cycle of latency, idle input produces spurious spikes.
  always @(posedge clk) net_o <= (net_i == '0) ? {OUT_N{1'b1}} : net_i[OUT_N-1:0];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cmd(input logic [2:0] op, input logic [28:0] pl);
    @(negedge clk);
    cmd_valid = 1'b1;
    data_in   = {op, pl};
    @(negedge clk);
    cmd_valid = 1'b0;
    data_in   = '0;
  endtask

  task automatic wait_done(input int c0, output int cyc);
    cyc = c0;
    while (!data_out[ST_DONE] && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic wr_frames(input int n, input logic [28:0] f);
    for (int i = 0; i < n; i++) cmd(OP_WRITE, f);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    #1;
    chk("reset_status", data_out, 32'h0);
    chk("reset_net_i", 32'(net_i), 32'h0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    chk("idle_status", data_out, 32'h0);

    // Basic run: 4 frames spiking class 3, one pass.
    wr_frames(4, 29'h4_0008);
    cmd(OP_START, 29'd1);
    chk("basic_busy", 32'(data_out[ST_BUSY]), 32'd1);
    chk("basic_net_i_s1", 32'(net_i), 32'h0);
    @(negedge clk);
    chk("basic_net_i_s2", 32'(net_i), 32'h4_0008);
    wait_done(2, lat);
    chk("basic_latency", lat, 18);
    chk("basic_status", data_out, 32'h4003_0000);
    cmd(OP_READ, 29'd3);
    chk("basic_read3", data_out, 32'h4003_0004);
    cmd(OP_READ, 29'd0);
    chk("basic_read0_noise", 32'(data_out[15:0]), 32'd0);
    cmd(OP_READ, 29'd12);
    chk("read_out_of_range", 32'(data_out[15:0]), 32'd0);

    // Multi-pass with a WRITE issued while busy.
    cmd(OP_CLEAR, 29'd0);
    chk("clear_status", data_out, 32'h0);
    wr_frames(4, 29'h008);
    cmd(OP_START, 29'd2);
    cmd(OP_WRITE, 29'h3FF);
    wait_done(3, lat);
    chk("pass2_latency", lat, 22);
    cmd(OP_READ, 29'd3);
    chk("pass2_read3", 32'(data_out[15:0]), 32'd8);
    cmd(OP_START, 29'd0);
    wait_done(1, lat);
    chk("write_dropped_latency", lat, 18);
    cmd(OP_READ, 29'd3);
    chk("p0_as_1_read3", 32'(data_out[15:0]), 32'd4);

    // Tie between classes 2 and 5 over 3 passes of 2 frames.
    cmd(OP_CLEAR, 29'd0);
    wr_frames(2, 29'h024);
    cmd(OP_START, 29'd3);
    wait_done(1, lat);
    chk("tie_latency", lat, 20);
    chk("tie_winner", 32'(data_out[19:16]), 32'd2);
    chk("tie_sat", 32'(data_out[ST_SAT]), 32'd0);
    cmd(OP_READ, 29'd2);
    chk("tie_read2", 32'(data_out[15:0]), 32'd6);
    cmd(OP_READ, 29'd5);
    chk("tie_read5", 32'(data_out[15:0]), 32'd6);

    // Saturation: class 0 spikes 20 times, class 4 spikes 14 times.
    cmd(OP_CLEAR, 29'd0);
    for (int i = 0; i < 20; i++) cmd(OP_WRITE, (i < 14) ? 29'h011 : 29'h001);
    cmd(OP_START, 29'd1);
    wait_done(1, lat);
    chk("sat_flag", 32'(data_out[ST_SAT]), 32'd1);
    chk("sat_winner", 32'(data_out[19:16]), 32'd0);
    cmd(OP_READ, 29'd0);
    chk("sat_read0", 32'(data_out[15:0]), 32'd15);
    cmd(OP_READ, 29'd4);
    chk("sat_read4", 32'(data_out[15:0]), 32'd14);

    // Buffer full: DEPTH writes fine, one more flags an error.
    cmd(OP_CLEAR, 29'd0);
    wr_frames(DEPTH, 29'h200);
    chk("full_no_err", 32'(data_out[ST_WR_ERR]), 32'd0);
    cmd(OP_WRITE, 29'h001);
    chk("full_wr_err", 32'(data_out[ST_WR_ERR]), 32'd1);
    cmd(OP_START, 29'd1);
    wait_done(1, lat);
    chk("full_latency", lat, 142);
    chk("full_winner", 32'(data_out[19:16]), 32'd9);

    // START with an empty buffer.
    cmd(OP_CLEAR, 29'd0);
    chk("empty_clear_err", 32'(data_out[ST_WR_ERR]), 32'd0);
    cmd(OP_START, 29'd1);
    chk("empty_start_err", 32'(data_out[ST_WR_ERR]), 32'd1);
    chk("empty_start_busy", 32'(data_out[ST_BUSY]), 32'd0);
    @(negedge clk);
    chk("empty_start_busy2", 32'(data_out[ST_BUSY]), 32'd0);

    // Abort a long run with CLEAR.
    cmd(OP_CLEAR, 29'd0);
    wr_frames(4, 29'h008);
    cmd(OP_START, 29'd200);
    repeat (5) @(negedge clk);
    chk("abort_pre_busy", 32'(data_out[ST_BUSY]), 32'd1);
    chk("abort_pre_net_i", 32'(net_i), 32'h008);
    cmd(OP_CLEAR, 29'd0);
    chk("abort_busy", 32'(data_out[ST_BUSY]), 32'd0);
    chk("abort_net_i", 32'(net_i), 32'h0);
    repeat (4) @(negedge clk);
    cmd(OP_READ, 29'd3);
    chk("abort_read3", 32'(data_out[15:0]), 32'd0);
    chk("abort_net_i_late", 32'(net_i), 32'h0);

    // Asynchronous reset in the middle of a run.
    wr_frames(4, 29'h008);
    cmd(OP_START, 29'd200);
    repeat (3) @(negedge clk);
    chk("rst_pre_busy", 32'(data_out[ST_BUSY]), 32'd1);
    #2;
    rstn = 1'b0;
    #1;
    chk("rst_mid_status", data_out, 32'h0);
    chk("rst_mid_net_i", 32'(net_i), 32'h0);
    @(negedge clk);
    rstn = 1'b1;
    cmd(OP_START, 29'd1);
    chk("rst_wr_ptr_zero", 32'(data_out[ST_WR_ERR]), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
